// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and a
// debug/loader port; every access is a fixed 4-cycle IDLE/CMD/WAIT/ACK walk.
module mem_arbiter #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AWIDTH-1:0] cpu_addr,
   input  logic [DWIDTH-1:0] cpu_wdata,
   output logic [DWIDTH-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_gnt,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [AWIDTH-1:0] dbg_addr,
   input  logic [DWIDTH-1:0] dbg_wdata,
   output logic [DWIDTH-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              dbg_gnt,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [DWIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WAIT,
      ACK
   } state_t;

   state_t state;
   state_t state_n;

   logic own_dbg;
   logic own_dbg_n;
   logic own_we;
   logic last_dbg;
   logic last_dbg_n;
   logic start;
   logic busy_n;

   logic              win_dbg;
   logic              win_we;
   logic [AWIDTH-1:0] win_addr;
   logic [DWIDTH-1:0] win_wdata;
   logic [DWIDTH-1:0] rd_val;

   // On a tie the port that was not granted last wins.
   assign win_dbg   = dbg_req & (~cpu_req | ~last_dbg);
   assign win_we    = win_dbg ? dbg_we    : cpu_we;
   assign win_addr  = win_dbg ? dbg_addr  : cpu_addr;
   assign win_wdata = win_dbg ? dbg_wdata : cpu_wdata;

   // Writes echo the written byte back to the owner instead of memory data.
   assign rd_val = own_we ? mem_wdata : mem_rdata;

   always_comb begin
      state_n    = state;
      own_dbg_n  = own_dbg;
      last_dbg_n = last_dbg;
      start      = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req | dbg_req) begin
               state_n    = CMD;
               start      = 1'b1;
               own_dbg_n  = win_dbg;
               last_dbg_n = win_dbg;
            end
         end
         CMD:     state_n = WAIT;
         WAIT:    state_n = ACK;
         ACK:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy_n = (state_n != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         own_dbg   <= 1'b0;
         own_we    <= 1'b0;
         last_dbg  <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_rd    <= 1'b0;
         cpu_gnt   <= 1'b0;
         dbg_gnt   <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         state    <= state_n;
         own_dbg  <= own_dbg_n;
         last_dbg <= last_dbg_n;
         mem_we   <= 1'b0;
         mem_rd   <= 1'b0;
         if (start) begin
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_we;
            mem_rd    <= ~win_we;
            own_we    <= win_we;
         end
         cpu_gnt <= busy_n & ~own_dbg_n;
         dbg_gnt <= busy_n &  own_dbg_n;
         cpu_ack <= (state == WAIT) & ~own_dbg;
         dbg_ack <= (state == WAIT) &  own_dbg;
         if (state == WAIT) begin
            if (own_dbg) begin
               dbg_rdata <= rd_val;
            end else begin
               cpu_rdata <= rd_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, corner sequences and random traffic
// compared every cycle against a transaction-level model with its own memory.
module tb_mem_arbiter;

   logic       clk;
   logic       rst;
   logic       cpu_req, cpu_we, dbg_req, dbg_we;
   logic [4:0] cpu_addr, dbg_addr, mem_addr;
   logic [7:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
   logic [7:0] mem_wdata, mem_rdata;
   logic       cpu_ack, cpu_gnt, dbg_ack, dbg_gnt, mem_we, mem_rd;

   int nvec  = 0;
   int nfail = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .cpu_gnt(cpu_gnt),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
      .dbg_ack(dbg_ack), .dbg_gnt(dbg_gnt),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous 32x8 memory the arbiter drives.
   logic [7:0] mem [32] = '{default: 8'h00};
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   // Reference: m_cnt counts cycles into the current access (0 = free).
   logic [7:0] ref_mem [32] = '{default: 8'h00};
   int         m_cnt  = 0;
   bit         m_own  = 1'b0;
   bit         m_last = 1'b1;
   bit         m_we   = 1'b0;
   logic [4:0] m_addr = '0;
   logic [7:0] m_wdata = '0;
   logic [7:0] m_rd [2] = '{8'h00, 8'h00};

   task automatic model_step();
      if (m_cnt == 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (rst) begin
         m_cnt = 0; m_last = 1'b1; m_own = 1'b0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_rd[0] = '0; m_rd[1] = '0;
      end else if (m_cnt == 0) begin
         if (cpu_req || dbg_req) begin
            m_own   = (cpu_req && dbg_req) ? !m_last : dbg_req;
            m_last  = m_own;
            m_we    = m_own ? dbg_we : cpu_we;
            m_addr  = m_own ? dbg_addr : cpu_addr;
            m_wdata = m_own ? dbg_wdata : cpu_wdata;
            m_cnt   = 1;
         end
      end else if (m_cnt == 2) begin
         m_rd[m_own] = m_we ? m_wdata : ref_mem[m_addr];
         m_cnt = 3;
      end else begin
         m_cnt = (m_cnt + 1) % 4;
      end
   endtask

   function automatic logic [34:0] act();
      return {cpu_gnt, cpu_ack, cpu_rdata, dbg_gnt, dbg_ack, dbg_rdata,
              mem_we, mem_rd, mem_addr, mem_wdata};
   endfunction

   function automatic logic [34:0] expv();
      return {m_cnt != 0 && !m_own, m_cnt == 3 && !m_own, m_rd[0],
              m_cnt != 0 && m_own, m_cnt == 3 && m_own, m_rd[1],
              m_cnt == 1 && m_we, m_cnt == 1 && !m_we, m_addr, m_wdata};
   endfunction

   task automatic chk(input string name, input logic [63:0] a,
                      input logic [63:0] e);
      nvec++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got %h want %h", name, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("outputs", 64'(act()), 64'(expv()));
   endtask

   function automatic logic gnt_of(bit p);
      return p ? dbg_gnt : cpu_gnt;
   endfunction
   function automatic logic ack_of(bit p);
      return p ? dbg_ack : cpu_ack;
   endfunction
   function automatic logic req_of(bit p);
      return p ? dbg_req : cpu_req;
   endfunction
   function automatic logic [7:0] rdata_of(bit p);
      return p ? dbg_rdata : cpu_rdata;
   endfunction

   task automatic drive(input bit p, input bit r, input bit w,
                        input logic [4:0] a, input logic [7:0] d);
      if (p) begin
         dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
      end else begin
         cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
      end
   endtask

   task automatic set_req(input bit p, input bit r);
      if (p) dbg_req = r;
      else cpu_req = r;
   endtask

   task automatic xact(input bit p, input bit w, input logic [4:0] a,
                       input logic [7:0] d, output logic [7:0] rd);
      drive(p, 1'b1, w, a, d);
      tick();
      chk("cmd_strobe", 64'({mem_we, mem_rd, gnt_of(p)}),
          64'({w, !w, 1'b1}));
      chk("cmd_addr", 64'(mem_addr), 64'(a));
      tick();
      tick();
      chk("ack_cycle3", 64'(ack_of(p)), 64'(1));
      rd = rdata_of(p);
      set_req(p, 1'b0);
      tick();
      chk("ack_done", 64'({cpu_ack, dbg_ack, cpu_gnt, dbg_gnt}), 64'(0));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) tick();
      rst = 1'b0;
   endtask

   typedef struct {
      bit         port;
      bit         we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t       tbl [8];
      logic [7:0] rd, va, vb;
      logic [7:0] prog [6];
      logic [4:0] paddr [6];
      int         n, cyc, seen;

      tbl[0] = '{1'b1, 1'b1, 5'd20, 8'h05, 8'h05};
      tbl[1] = '{1'b1, 1'b0, 5'd20, 8'h00, 8'h05};
      tbl[2] = '{1'b0, 1'b1, 5'd7,  8'hA5, 8'hA5};
      tbl[3] = '{1'b1, 1'b0, 5'd7,  8'h11, 8'hA5};
      tbl[4] = '{1'b0, 1'b0, 5'd20, 8'h00, 8'h05};
      tbl[5] = '{1'b1, 1'b1, 5'd31, 8'hFF, 8'hFF};
      tbl[6] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'hFF};
      tbl[7] = '{1'b0, 1'b1, 5'd0,  8'h3C, 8'h3C};

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);

      do_reset(2);
      chk("reset_outputs", 64'(act()), 64'(0));

      for (int i = 0; i < 8; i++) begin
         xact(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
         chk("table_rdata", 64'(rd), 64'(tbl[i].exp));
      end

      // Tie after reset goes to the CPU, then strict alternation.
      do_reset(2);
      drive(1'b0, 1'b1, 1'b0, 5'd0, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 5'd21, 8'h00);
      n = 0;
      cyc = 0;
      while (n < 6 && cyc < 40) begin
         tick();
         cyc++;
         if (cpu_ack || dbg_ack) begin
            chk("alt_owner", 64'(dbg_ack), 64'(n % 2));
            chk("alt_cycle", 64'(cyc), 64'(3 + 4 * n));
            n++;
         end
      end
      chk("alt_count", 64'(n), 64'(6));
      set_req(1'b0, 1'b0);
      set_req(1'b1, 1'b0);
      tick();
      tick();

      // Program load over debug, then a CPU-side run of the image.
      prog  = '{8'hB4, 8'h55, 8'hD6, 8'h00, 8'h05, 8'h03};
      paddr = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd20, 5'd21};
      for (int i = 0; i < 6; i++) xact(1'b1, 1'b1, paddr[i], prog[i], rd);
      xact(1'b0, 1'b0, 5'd0, 8'h00, rd);
      chk("run_fetch0", 64'(rd), 64'(8'hB4));
      xact(1'b0, 1'b0, 5'd20, 8'h00, va);
      xact(1'b0, 1'b0, 5'd1, 8'h00, rd);
      chk("run_fetch1", 64'(rd), 64'(8'h55));
      xact(1'b0, 1'b0, 5'd21, 8'h00, vb);
      xact(1'b0, 1'b1, 5'd22, va + vb, rd);
      xact(1'b1, 1'b0, 5'd22, 8'h00, rd);
      chk("sto_readback", 64'(rd), 64'(8'h08));

      // Debug request raised and withdrawn while the CPU owns memory.
      drive(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
      tick();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 8'h00);
      seen = 0;
      tick();
      seen += int'(dbg_ack | dbg_gnt);
      set_req(1'b1, 1'b0);
      tick();
      seen += int'(dbg_ack | dbg_gnt);
      set_req(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         seen += int'(dbg_ack | dbg_gnt);
      end
      chk("withdraw_no_dbg", 64'(seen), 64'(0));

      // Dropping req after grant still completes the access.
      drive(1'b1, 1'b1, 1'b0, 5'd20, 8'h00);
      tick();
      set_req(1'b1, 1'b0);
      tick();
      tick();
      chk("late_drop_ack", 64'({dbg_ack, dbg_rdata}), 64'({1'b1, 8'h05}));
      tick();

      // Reset while a CPU read is in WAIT.
      drive(1'b0, 1'b1, 1'b0, 5'd20, 8'h00);
      tick();
      tick();
      rst = 1'b1;
      set_req(1'b0, 1'b0);
      tick();
      chk("mid_reset_quiet", 64'({cpu_ack, cpu_gnt, mem_we, mem_rd}),
          64'(0));
      rst = 1'b0;
      xact(1'b0, 1'b0, 5'd20, 8'h00, rd);
      chk("after_reset_read", 64'(rd), 64'(8'h05));

      // Random traffic obeying the requester rules.
      for (int i = 0; i < 800; i++) begin
         for (int p = 0; p < 2; p++) begin
            bit pb;
            pb = bit'(p);
            if (req_of(pb)) begin
               if (ack_of(pb)) begin
                  if ($urandom % 2 == 0)
                     drive(pb, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
                  else
                     set_req(pb, 1'b0);
               end else if (!gnt_of(pb) && $urandom % 8 == 0) begin
                  set_req(pb, 1'b0);
               end else if (gnt_of(pb) && $urandom % 16 == 0) begin
                  set_req(pb, 1'b0);
               end
            end else if (!gnt_of(pb) && $urandom % 3 == 0) begin
               drive(pb, 1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
            end
         end
         tick();
      end
      set_req(1'b0, 1'b0);
      set_req(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the CPU's single-port 32x8 instruction/data memory between the CPU memory interface and a debug/loader port. Program images can be loaded, and results such as the STO target location read back, over the debug port through RTL instead of hierarchical backdoor writes, with the CPU running or halted. It sits between `risc_cpu`'s memory request path, the debug port and the memory array. Arbitration is round-robin, one access at a time, with a fixed 4-cycle transaction.

## Interface
Parameters:
- AWIDTH, 5, memory address width (32 locations)
- DWIDTH, 8, memory data width

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  in  AWIDTH  CPU address
- cpu_wdata  in  DWIDTH  CPU write data
- cpu_rdata  out  DWIDTH  read data; valid while cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_gnt  out  1  CPU owns the memory (CMD, WAIT and ACK states)
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_gnt  same directions, widths and meanings as the cpu_* ports, for the debug port
- mem_addr  out  AWIDTH  memory address, registered
- mem_wdata  out  DWIDTH  memory write data, registered
- mem_we  out  1  memory write strobe; one cycle, registered
- mem_rd  out  1  memory read strobe; one cycle, registered
- mem_rdata  in  DWIDTH  synchronous memory read data; valid the cycle after mem_rd

## Operation
- States:
  - IDLE: samples requests.
  - CMD: the memory command is on mem_*.
  - WAIT: memory data is returning.
  - ACK: ack and rdata are presented to the owner.
- Transitions:
  - IDLE -> CMD when any req is high; otherwise stay in IDLE.
  - CMD -> WAIT -> ACK -> IDLE, unconditionally.
- Winner selection:
  - Only one requester high: it wins.
  - Both high: the port not granted last wins.
  - The last-grant pointer updates on entry to CMD.
  - Reset sets the pointer to DBG, so the CPU wins the first tie.
- Owner: latched on IDLE -> CMD and held through ACK. Requests are ignored outside IDLE.
- mem_* during CMD:
  - mem_addr and mem_wdata come from the owner.
  - mem_we = owner_we.
  - mem_rd = !owner_we.
  - Outside CMD, mem_we = mem_rd = 0, and mem_addr/mem_wdata hold their last value.
- Read data: mem_rdata is captured at the end of WAIT into the owner's rdata register.
- Write data: on a write, the owner's rdata register loads the written data, as an echo.
- Ack:
  - x_ack = 1 only in ACK and only for the owner.
  - The non-owner's ack stays 0.
  - The non-owner's rdata register is unchanged.
- Requester rules:
  - Hold req and all request fields stable until ack.
  - Dropping req before grant withdraws the request.
  - Dropping req after grant does not abort: the access completes and the ack still pulses.
  - A requester may keep req high through ack to start a new transaction. That transaction is re-arbitrated in the following IDLE cycle.
- Fairness: under continuous requests from both ports, grants alternate CPU, DBG, CPU, and so on. Worst-case wait for any port is 8 cycles from IDLE.
- Reset, including mid-transaction:
  - Next state is IDLE and any in-flight access is dropped with no ack.
  - mem_we, mem_rd, both acks and both gnts are 0 from the cycle after the rst edge.
  - mem_addr, mem_wdata, cpu_rdata and dbg_rdata reset to 0.
  - The last-grant pointer resets to DBG.

## Timing
- Request sampled high in IDLE in cycle 0:
  - CMD in cycle 1, with mem_we or mem_rd high.
  - WAIT in cycle 2.
  - ACK in cycle 3, with x_ack high and x_rdata valid.
  - IDLE in cycle 4.
- Latency from req to ack is 3 cycles. Throughput is one access per 4 cycles.
- gnt is high in cycles 1 to 3.
- mem_we and mem_rd are never high together and are never high outside CMD.
- cpu_ack and dbg_ack are never high in the same cycle.
- All outputs are registered. No combinational path runs from any input to any output.

## Test plan
- Reset check: hold rst for 2 cycles -> all outputs 0; the next tie goes to the CPU.
- Single debug write then read:
  - dbg write addr 20 = 8'h05 -> mem_we high in cycle 1, dbg_ack in cycle 3, dbg_rdata = 8'h05 (echo).
  - dbg read addr 20 -> mem_rd in cycle 1, dbg_ack in cycle 3 with dbg_rdata = 8'h05.
- Simultaneous requests after reset (cpu read addr 0, dbg read addr 21) -> CPU acked in cycle 3, DBG acked in cycle 7; with both held high continuously, grants alternate over 6 transactions.
- Program load then run:
  - Via dbg, write 8'hB4, 8'h55, 8'hD6, 8'h00 to addrs 0-3, 8'h05 to addr 20 and 8'h03 to addr 21.
  - Release the CPU -> CPU reads at 0, 20, 1, 21, then writes addr 22.
  - A dbg read of addr 22 after halt returns 8'h08.
- Request withdrawal: dbg_req high, then low, while the CPU owns the memory -> no debug transaction and dbg_ack stays 0. Separately, dbg_req dropped in CMD -> the access completes and dbg_ack pulses in cycle 3.
- Reset mid-transaction: assert rst in WAIT of a cpu read -> no cpu_ack, IDLE on the next cycle, and a subsequent request completes normally with 3-cycle latency.
